// File: rtl/seg_scan.sv
// Multiplexed 7-segment scanner: walks NUM_DIGITS anodes with a blanking gap between digits,
// double-buffering the loaded pattern so a new value only appears from the next frame start.
module seg_scan #(
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        I_CLK,
  input  logic        Rst,
  input  logic        I_TICK,
  input  logic        I_LOAD,
  input  logic [31:0] I_DATA,
  input  logic [7:0]  I_MASK,
  input  logic [7:0]  I_DP,
  output logic [7:0]  O_AN,
  output logic [7:0]  O_SEG,
  output logic        O_FRAME
);

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

  localparam logic [2:0] LAST_IDX  = 3'(NUM_DIGITS - 1);
  localparam logic [8:0] BLANK_LEN = 9'(BLANK_CYCLES);

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        blank_done;
  logic        frame_nxt;

  logic [31:0] shadow_data, disp_data, use_data;
  logic [7:0]  shadow_mask, disp_mask, use_mask;
  logic [7:0]  shadow_dp, disp_dp, use_dp;
  logic [7:0]  an_nxt, seg_nxt;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] seg_word(input logic [31:0] data, input logic [7:0] dp,
                                          input logic [2:0] sel);
    return ~{dp[sel], decode(data[{sel, 2'b00} +: 4])};
  endfunction

  // A count of zero and one both leave BLANK on the very next edge.
  assign blank_done = ({1'b0, cnt} + 9'd1 >= BLANK_LEN);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    frame_nxt = 1'b0;
    case (state)
      BLANK: begin
        if (blank_done) begin
          state_nxt = SHOW;
          frame_nxt = (idx == 3'd0);
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        if (I_TICK) begin
          idx_nxt = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
          cnt_nxt = 8'd0;
          if (BLANK_CYCLES == 0) begin
            frame_nxt = (idx_nxt == 3'd0);
          end else begin
            state_nxt = BLANK;
          end
        end
      end
    endcase
  end

  // Outputs are registered from next-state values so they move on the same edge as the state.
  always_comb begin
    use_data = frame_nxt ? shadow_data : disp_data;
    use_mask = frame_nxt ? shadow_mask : disp_mask;
    use_dp   = frame_nxt ? shadow_dp   : disp_dp;
    an_nxt   = 8'hFF;
    seg_nxt  = 8'hFF;
    if (state_nxt == SHOW) begin
      seg_nxt = seg_word(use_data, use_dp, idx_nxt);
      if (use_mask[idx_nxt]) an_nxt = ~(8'd1 << idx_nxt);
    end
  end

  always_ff @(posedge I_CLK or posedge Rst) begin
    if (Rst) begin
      state       <= BLANK;
      idx         <= 3'd0;
      cnt         <= 8'd0;
      shadow_data <= 32'd0;
      shadow_mask <= 8'd0;
      shadow_dp   <= 8'd0;
      disp_data   <= 32'd0;
      disp_mask   <= 8'd0;
      disp_dp     <= 8'd0;
      O_AN        <= 8'hFF;
      O_SEG       <= 8'hFF;
      O_FRAME     <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      O_AN    <= an_nxt;
      O_SEG   <= seg_nxt;
      O_FRAME <= frame_nxt;
      if (I_LOAD) begin
        shadow_data <= I_DATA;
        shadow_mask <= I_MASK;
        shadow_dp   <= I_DP;
      end
      // Display takes the pre-load shadow even when a load lands on the boundary edge.
      if (frame_nxt) begin
        disp_data <= shadow_data;
        disp_mask <= shadow_mask;
        disp_dp   <= shadow_dp;
      end
    end
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named I_CLK and Rst.
REQ-002 Parameter NUM_DIGITS, default 8, range 1..8: number of scanned digits.
REQ-003 Parameter BLANK_CYCLES, default 4, range 0..255: I_CLK cycles with all anodes off between digits.
REQ-004 I_CLK  in  1  system clock; all state changes on its rising edge.
REQ-005 Rst  in  1  asynchronous active-high reset.
REQ-006 I_TICK  in  1  one-cycle scan-advance strobe, synchronous to I_CLK, from the upstream divider.
REQ-007 I_LOAD  in  1  capture strobe for I_DATA, I_MASK and I_DP.
REQ-008 I_DATA  in  32  eight hex nibbles; nibble k (bits 4k+3:4k) belongs to digit k.
REQ-009 I_MASK  in  8  digit enable; bit k = 0 keeps digit k dark.
REQ-010 I_DP  in  8  decimal point; bit k = 1 lights DP of digit k.
REQ-011 O_AN  out  8  anode select, active-low, registered.
REQ-012 O_SEG  out  8  segments, active-low, registered; bit0..6 = a..g, bit7 = dp.
REQ-013 O_FRAME  out  1  one-cycle pulse on each frame boundary, registered.

Function
REQ-014 I_LOAD high at a clock edge SHALL copy I_DATA/I_MASK/I_DP into shadow registers.
REQ-015 Shadow contents SHALL copy into display registers only at a frame boundary, i.e. the edge that enters SHOW with digit index 0.
REQ-016 At a frame boundary coinciding with I_LOAD, the display SHALL take the pre-load shadow value; the new value appears next frame.
REQ-017 FSM states: BLANK and SHOW; digit index idx is 0..NUM_DIGITS-1.
REQ-018 BLANK: O_AN = 8'hFF, O_SEG = 8'hFF; the block stays BLANK_CYCLES edges, then enters SHOW with the current idx.
REQ-019 SHOW: O_AN = ~(1<<idx) if mask[idx] = 1, else 8'hFF; O_SEG = ~{dp[idx], decode(nibble idx)}.
REQ-020 I_TICK sampled high in SHOW: idx <= (idx = NUM_DIGITS-1) ? 0 : idx+1; state goes to BLANK, or directly to SHOW if BLANK_CYCLES = 0.
REQ-021 I_TICK in BLANK SHALL be ignored; no queuing.
REQ-022 O_AN, O_SEG and O_FRAME SHALL change on the same edge as the state/idx change they reflect.
REQ-023 O_FRAME SHALL be high for exactly the one cycle following a frame-boundary edge.
REQ-024 decode (gfedcba, active-high before inversion): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-025 Nibbles, mask bits and dp bits at index >= NUM_DIGITS SHALL be ignored; O_AN bits >= NUM_DIGITS SHALL stay 1.
REQ-026 With NUM_DIGITS = 1, every SHOW entry after a tick SHALL be a frame boundary.
REQ-027 At most one anode SHALL be low in any cycle.

Reset
REQ-028 Rst high SHALL immediately, without a clock, force: state BLANK, blank counter 0, idx 0, shadow and display registers 0, O_AN = 8'hFF, O_SEG = 8'hFF, O_FRAME = 0.
REQ-029 After Rst deasserts, the block SHALL enter SHOW idx 0 after BLANK_CYCLES edges; this is a frame boundary.
REQ-030 Rst asserted mid-SHOW or mid-BLANK SHALL discard any pending load and restart per REQ-029.

Verification
REQ-031 Defaults; load I_DATA = 32'h76543210, I_MASK = 8'hFF, I_DP = 0 during reset release; tick every 10 clocks -> digit 0 shows O_AN = 8'hFE, O_SEG = 8'hC0; after the next tick O_AN = 8'hFF for exactly 4 cycles, then 8'hFD with O_SEG = 8'hF9.
REQ-032 Continue the REQ-031 setup through the wrap from digit 7 -> O_FRAME pulses one cycle on entering digit 0; O_AN sequence is FE, FD, FB, F7, EF, DF, BF, 7F, with BLANK gaps between.
REQ-033 Mid-frame load 32'hFFFFFFFF with I_MASK = 8'h0F, I_DP = 8'h01 -> the current frame keeps the old digits; the next frame shows digit 0 O_SEG = 8'h0E and digits 1..3 O_SEG = 8'h8E, with O_AN = 8'hFF during digits 4..7.
REQ-034 BLANK_CYCLES = 0, NUM_DIGITS = 4 -> each tick switches the anode directly with no FF cycle; the wrap from 3 to 0 pulses O_FRAME.
REQ-035 Tick during BLANK, then load coincident with a frame boundary -> the blank-phase tick has no effect; the coincident load is displayed one frame later.
REQ-036 Assert Rst asynchronously between clock edges while in SHOW -> O_AN/O_SEG go to 8'hFF before the next edge; restart per REQ-029 with blank display.
